pll_reset_sequencer: RTL and testbench

// - Sits directly downstream of the 48->100 MHz PLL wrapper; runs on the PLL output clock.
// - Synchronises the PLL locked flag and qualifies it for a stable period.
// - Produces a clean synchronous system reset and a ready flag for the 100 MHz fabric.
// - Detects and records loss of lock, re-sequencing reset whenever lock drops.

---
 rtl/pll_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Qualifies the PLL lock flag on the PLL output clock and sequences a clean
// synchronous system reset for the 100 MHz fabric. Loss of lock while running
// forces the fabric back into reset and is recorded in a sticky flag.
// Optional feature macro: PLL_RSTSEQ_LOSS_COUNT_EN
//   defined   -> saturating lock_loss_count register is implemented
//   undefined -> lock_loss_count is tied to zero
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int COUNT_WIDTH        = 8
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   clear_sticky,
  output logic                   sys_reset,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [COUNT_WIDTH-1:0] lock_loss_count
);

  // One shared down-counter serves both the stable-lock and reset-hold phases.
  localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                              LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_WIDTH  = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_WIDTH-1:0] STABLE_LOAD = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sync_1;
  logic                 sync_2;
  logic                 lock_s;

  // Two-flop synchroniser: the only place the raw PLL lock flag is sampled.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= locked;
      sync_2 <= sync_1;
    end
  end

  assign lock_s = sync_2;

  // Sequencer FSM; outputs are registered and always reflect the state being entered.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= ST_WAIT;
      cnt       <= '0;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
`ifdef PLL_RSTSEQ_LOSS_COUNT_EN
      lock_loss_count <= '0;
`endif
    end else begin
      // Clear is applied first so that a loss on the same edge overrides it.
      if (clear_sticky) begin
        lock_lost <= 1'b0;
      end
      case (state)
        ST_WAIT: begin
          sys_reset <= 1'b1;
          ready     <= 1'b0;
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= STABLE_LOAD;
          end
        end
        ST_STABLE: begin
          sys_reset <= 1'b1;
          ready     <= 1'b0;
          if (!lock_s) begin
            state <= ST_WAIT;
          end else if (cnt == '0) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state     <= ST_WAIT;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
          end else if (cnt == '0) begin
            state     <= ST_RUN;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            cnt       <= cnt - 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state     <= ST_WAIT;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
`ifdef PLL_RSTSEQ_LOSS_COUNT_EN
            if (lock_loss_count != '1) begin
              lock_loss_count <= lock_loss_count + 1'b1;
            end
`endif
          end else begin
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end
        end
        default: begin
          state     <= ST_WAIT;
          sys_reset <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

`ifndef PLL_RSTSEQ_LOSS_COUNT_EN
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Directed and randomized stimulus for pll_reset_sequencer, compared every
// cycle against a model based on the run length of synchronised lock.
// Honours PLL_RSTSEQ_LOSS_COUNT_EN for the expected loss count.
module tb_pll_reset_sequencer;

  localparam int LSC = 16;
  localparam int RHC = 4;
  localparam int CW  = 2;
  localparam int RUN_LEN = LSC + RHC + 1;

  logic          clock_in;
  logic          reset;
  logic          locked;
  logic          clear_sticky;
  logic          sys_reset;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  // Model: lock seen through a two-stage delay, fabric runs once synchronised
  // lock has been continuously high for RUN_LEN consecutive edges.
  logic m_p1, m_p2;
  int   m_run;
  logic m_ready;
  logic m_lost;
  int   m_count;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC),
    .COUNT_WIDTH       (CW)
  ) dut (
    .clock_in       (clock_in),
    .reset          (reset),
    .locked         (locked),
    .clear_sticky   (clear_sticky),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .lock_lost      (lock_lost),
    .lock_loss_count(lock_loss_count)
  );

  // 100 MHz clock.
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  function automatic logic [CW-1:0] expCount();
`ifdef PLL_RSTSEQ_LOSS_COUNT_EN
    return CW'(m_count);
`else
    return '0;
`endif
  endfunction

  task automatic modelEdge(input logic lk, input logic clr, input logic rst);
    logic ls;
    logic was_ready;
    if (rst) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_run = 0;
      m_ready = 1'b0; m_lost = 1'b0; m_count = 0;
    end else begin
      ls = m_p2;
      m_p2 = m_p1;
      m_p1 = lk;
      was_ready = m_ready;
      if (ls) m_run = (m_run < RUN_LEN) ? m_run + 1 : RUN_LEN;
      else m_run = 0;
      m_ready = (m_run >= RUN_LEN);
      if (was_ready && !ls) begin
        m_lost = 1'b1;
        if (m_count < (1 << CW) - 1) m_count = m_count + 1;
      end else if (clr) begin
        m_lost = 1'b0;
      end
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input logic [CW-1:0] exp);
    checks++;
    assert (lock_loss_count === exp) else begin
      errors++;
      $error("[TB] FAIL %s count observed=%0d expected=%0d", tag, lock_loss_count, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBit({tag, ".sys_reset"}, sys_reset, ~m_ready);
    checkBit({tag, ".ready"}, ready, m_ready);
    checkBit({tag, ".lock_lost"}, lock_lost, m_lost);
    checkCount(tag, expCount());
  endtask

  // Drive inputs, take one clock edge, advance the model and compare #1 later.
  task automatic applyStimulus(input logic lk, input logic clr, input logic rst, input string tag);
    locked       = lk;
    clear_sticky = clr;
    reset        = rst;
    @(posedge clock_in);
    modelEdge(lk, clr, rst);
    #1;
    checkOutput(tag);
  endtask

  task automatic lossFromRun(input logic clr_on_loss, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, tag);
    applyStimulus(1'b0, 1'b0, 1'b0, tag);
    checkBit({tag, ".still_ready"}, ready, 1'b1);
    applyStimulus(1'b0, clr_on_loss, 1'b0, tag);
    checkBit({tag, ".sys_reset_up"}, sys_reset, 1'b1);
    checkBit({tag, ".ready_down"}, ready, 1'b0);
    checkBit({tag, ".lost_set"}, lock_lost, 1'b1);
  endtask

  task automatic acquire(input string tag);
    for (int i = 1; i <= 23; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, tag);
      if (i == 22) checkBit({tag, ".not_before_23"}, sys_reset, 1'b1);
      if (i == 23) begin
        checkBit({tag, ".release_at_23"}, sys_reset, 1'b0);
        checkBit({tag, ".ready_at_23"}, ready, 1'b1);
      end
    end
  endtask

  initial begin
    logic lk;
    int   len;
    int   cyc;
    m_p1 = 1'b0; m_p2 = 1'b0; m_run = 0;
    m_ready = 1'b0; m_lost = 1'b0; m_count = 0;
    locked = 1'b0; clear_sticky = 1'b0; reset = 1'b1;

    // Reset held while locked toggles.
    for (int i = 0; i < 6; i++) begin
      lk = i[0];
      applyStimulus(lk, 1'b0, 1'b1, "reset_hold");
    end
    checkBit("reset.sys_reset", sys_reset, 1'b1);
    checkBit("reset.ready", ready, 1'b0);
    checkBit("reset.lock_lost", lock_lost, 1'b0);
    checkCount("reset.count", '0);

    // Release reset, acquire lock.
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "idle");
    acquire("acquire1");

    // First loss of lock, then clear the sticky flag.
    lossFromRun(1'b0, "loss1");
    checkCount("loss1.count", expCount());
    applyStimulus(1'b0, 1'b1, 1'b0, "clear1");
    checkBit("clear1.lost_cleared", lock_lost, 1'b0);

    // Brief drop during qualification restarts the full sequence.
    repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, "dropout_pre");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, "dropout_low");
    acquire("dropout_reacq");
    checkBit("dropout.lost_clear", lock_lost, 1'b0);

    // Losses 2..5; clear_sticky coincides with the fifth loss.
    for (int n = 2; n <= 5; n++) begin
      lossFromRun(n == 5, "loss_n");
      if (n < 5) acquire("reacq_n");
    end
    checkBit("loss5.lost_set_wins", lock_lost, 1'b1);
`ifdef PLL_RSTSEQ_LOSS_COUNT_EN
    checkCount("loss5.saturated", 2'd3);
`else
    checkCount("loss5.no_counter", 2'd0);
`endif

    // Reset while in the hold phase.
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, "to_hold");
    applyStimulus(1'b1, 1'b0, 1'b1, "reset_in_hold");
    checkBit("hold_reset.sys_reset", sys_reset, 1'b1);
    checkBit("hold_reset.ready", ready, 1'b0);
    checkBit("hold_reset.lock_lost", lock_lost, 1'b0);
    checkCount("hold_reset.count", '0);

    // Randomized lock behaviour with occasional clears and resets.
    cyc = 0;
    while (cyc < 1500) begin
      lk  = logic'($urandom_range(0, 1));
      len = lk ? $urandom_range(5, 40) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        applyStimulus(lk, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0), "random");
        cyc++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
